// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, status bit positions and types for the PS/2 scancode receiver
package ps2_pkg;
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_RLS = 8'hF0;
    localparam int STAT_OVF  = 7;
    localparam int STAT_PERR = 6;
    localparam int STAT_EXT  = 5;
    localparam int STAT_RLS  = 4;
    localparam int STAT_CNT  = 1;
    localparam int STAT_NE   = 0;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef struct packed {
        logic       ext;
        logic       rls;
        logic [7:0] code;
    } scan_ev_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the PS/2 lines and deserialises one frame per stop bit
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 28000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_in,
    input  logic       data_in,
    input  logic       enable_rcv,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [7:0] frame_byte
);
    localparam int unsigned TO_CYC = 32'((64'(CLK_HZ) * 64'(TIMEOUT_US)) / 64'd1000000);
    localparam int TW = $clog2(TO_CYC + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0] pin, lvl, flip;
    assign pin = {data_in, clk_in};

    // a filtered level only follows the pin after FILTER_LEN disagreeing samples
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic s0, s1, lv;
        logic [FW-1:0] cnt;
        assign lvl[i]  = lv;
        assign flip[i] = (s1 != lv) && (cnt == FW'(FILTER_LEN - 1));
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                s0  <= 1'b1;
                s1  <= 1'b1;
                lv  <= 1'b1;
                cnt <= '0;
            end else begin
                s0  <= pin[i];
                s1  <= s0;
                lv  <= flip[i] ? s1 : lv;
                cnt <= (s1 == lv || flip[i]) ? '0 : cnt + 1'b1;
            end
    end

    rx_state_t state, state_nx;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par, fall, d, expired, good;
    logic [TW-1:0] tmo;

    assign fall    = lvl[0] & flip[0];
    assign d       = lvl[1];
    assign expired = (tmo == '0) && (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RX_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (!enable_rcv) state_nx = RX_IDLE;
        else if (fall)
            case (state)
                RX_IDLE:   state_nx = d ? RX_IDLE : RX_DATA;
                RX_DATA:   state_nx = (bit_cnt == 3'd7) ? RX_PARITY : RX_DATA;
                RX_PARITY: state_nx = RX_STOP;
                default:   state_nx = RX_IDLE;
            endcase
        else if (expired) state_nx = RX_IDLE;
    end

    always_comb begin
        good        = ^{shreg, par} & d;
        frame_valid = enable_rcv && fall && (state == RX_STOP) && good;
        frame_err   = enable_rcv && fall && (state == RX_STOP) && !good;
    end
    assign frame_byte = shreg;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tmo     <= '0;
        end else begin
            tmo <= fall ? TW'(TO_CYC) : (tmo == '0) ? tmo : tmo - 1'b1;
            if (!enable_rcv || state == RX_IDLE) bit_cnt <= '0;
            else if (fall && state == RX_DATA) bit_cnt <= bit_cnt + 1'b1;
            if (fall && state == RX_DATA) shreg <= {d, shreg[7:1]};
            if (fall && state == RX_PARITY) par <= d;
        end
endmodule

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: folds E0/F0 prefixes into events and queues them behind the ZX-Uno register bus
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int         CLK_HZ     = 28000000,
    parameter int         FIFO_DEPTH = 16,
    parameter int         FILTER_LEN = 8,
    parameter int         TIMEOUT_US = 2000,
    parameter logic [7:0] REG_DATA   = 8'h04,
    parameter logic [7:0] REG_STAT   = 8'h05
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        clkps2,
    inout  wire        dataps2,
    input  logic       enable_rcv,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    output logic       scan_valid,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic frame_valid, frame_err;
    logic [7:0] frame_byte;

    ps2_frame_rx #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_in     (clkps2),
        .data_in    (dataps2),
        .enable_rcv (enable_rcv),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .frame_byte (frame_byte)
    );

    logic ext_pend, rls_pend, ovf, perr, rd_q;
    logic is_ext, is_rls, push, pop, flush, wr_stat, rd_data, do_push, do_pop, full, ne;
    logic unused_din;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [2:0] cnt_sat;
    logic [7:0] stat;
    scan_ev_t mem [FIFO_DEPTH];
    scan_ev_t head;

    assign is_ext     = frame_byte == PS2_PFX_EXT;
    assign is_rls     = frame_byte == PS2_PFX_RLS;
    assign push       = frame_valid && !is_ext && !is_rls;
    assign rd_data    = zxuno_regrd && zxuno_addr == REG_DATA;
    assign wr_stat    = zxuno_regwr && zxuno_addr == REG_STAT;
    assign flush      = wr_stat && din[0];
    assign full       = count == CW'(FIFO_DEPTH);
    assign ne         = count != '0;
    // pop once, on the first cycle after a data-register read strobe ends
    assign pop        = rd_q && !rd_data && ne;
    assign do_pop     = pop && !flush;
    assign do_push    = push && !flush && (!full || pop);
    assign head       = mem[rptr];
    assign cnt_sat    = (32'(count) > 32'd7) ? 3'd7 : 3'(count);
    assign unused_din = ^din[5:1];

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= {ext_pend, rls_pend, frame_byte};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q       <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            perr       <= 1'b0;
            ext_pend   <= 1'b0;
            rls_pend   <= 1'b0;
            scan_valid <= 1'b0;
            scancode   <= '0;
            extended   <= 1'b0;
            released   <= 1'b0;
        end else begin
            rd_q       <= rd_data;
            wptr       <= flush ? '0 : wptr + AW'(do_push);
            rptr       <= flush ? '0 : rptr + AW'(do_pop);
            count      <= flush ? '0 : count + CW'(do_push) - CW'(do_pop);
            ovf        <= (ovf && !(wr_stat && din[7])) || (push && full && !pop && !flush);
            perr       <= (perr && !(wr_stat && din[6])) || frame_err;
            ext_pend   <= (frame_err || push) ? 1'b0 : ext_pend || (frame_valid && is_ext);
            rls_pend   <= (frame_err || push) ? 1'b0 : rls_pend || (frame_valid && is_rls);
            scan_valid <= push;
            if (push) begin
                scancode <= frame_byte;
                extended <= ext_pend;
                released <= rls_pend;
            end
        end

    always_comb begin
        stat                  = '0;
        stat[STAT_OVF]        = ovf;
        stat[STAT_PERR]       = perr;
        stat[STAT_EXT]        = ne && head.ext;
        stat[STAT_RLS]        = ne && head.rls;
        stat[STAT_CNT +: 3]   = cnt_sat;
        stat[STAT_NE]         = ne;
        oe   = zxuno_regrd && (zxuno_addr == REG_DATA || zxuno_addr == REG_STAT);
        dout = !oe ? 8'h00 : (zxuno_addr == REG_DATA) ? (ne ? head.code : 8'h00) : stat;
    end
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb_ps2_scan_fifo: directed frames and register accesses with hand-computed expectations
module tb_ps2_scan_fifo;
    localparam logic [7:0] RD = 8'h04;
    localparam logic [7:0] RS = 8'h05;

    logic clk = 1'b0, rst_n = 1'b0, c_drv = 1'b1, d_drv = 1'b1, enable_rcv = 1'b1;
    logic zxuno_regrd = 1'b0, zxuno_regwr = 1'b0;
    logic [7:0] zxuno_addr = 8'h00, din = 8'h00;
    logic [7:0] dout, scancode;
    logic oe, scan_valid, extended, released;
    wire clkps2, dataps2;
    int checks = 0, errors = 0;
    logic [9:0] ev_q [$];

    assign clkps2  = c_drv;
    assign dataps2 = d_drv;
    always #5 clk = ~clk;

    ps2_scan_fifo #(
        .CLK_HZ    (1000000),
        .FIFO_DEPTH(8),
        .FILTER_LEN(4),
        .TIMEOUT_US(200),
        .REG_DATA  (RD),
        .REG_STAT  (RS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clkps2     (clkps2),
        .dataps2    (dataps2),
        .enable_rcv (enable_rcv),
        .zxuno_addr (zxuno_addr),
        .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr),
        .din        (din),
        .dout       (dout),
        .oe         (oe),
        .scan_valid (scan_valid),
        .scancode   (scancode),
        .extended   (extended),
        .released   (released)
    );

    always @(negedge clk)
        if (scan_valid) ev_q.push_back({extended, released, scancode});

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // act 1: end a held data read, act 2: flush write, both timed onto the push edge
    task automatic ps2_bit(input logic b, input int act);
        @(negedge clk);
        d_drv = b;
        repeat (10) @(negedge clk);
        c_drv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (act == 1 && i == 4) zxuno_regrd = 1'b0;
            if (act == 2 && i == 4) begin zxuno_addr = RS; din = 8'h01; zxuno_regwr = 1'b1; end
            if (act == 2 && i == 5) begin zxuno_regwr = 1'b0; din = 8'h00; end
        end
        c_drv = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad, input int act);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
        ps2_bit(~^b ^ bad, 0);
        ps2_bit(1'b1, act);
        repeat (5) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a, input int hold, output logic [7:0] val);
        @(negedge clk);
        zxuno_addr  = a;
        zxuno_regrd = 1'b1;
        #1 val = dout;
        repeat (hold) @(negedge clk);
        zxuno_regrd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        zxuno_addr  = a;
        din         = d;
        zxuno_regwr = 1'b1;
        @(negedge clk);
        zxuno_regwr = 1'b0;
        din         = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({oe, scan_valid, extended, released, scancode, dout}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        zxuno_addr  = RS;
        zxuno_regrd = 1'b1;
        #1 chk("oe_stat", 32'(oe), 1);
        chk("rst_stat", 32'(dout), 'h00);
        zxuno_regrd = 1'b0;

        send_frame(8'h1C, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 0);
        chk("mb_events", 32'(ev_q.size()), 2);
        chk("mb_ev0", 32'(ev_q[0]), 'h01C);
        chk("mb_ev1", 32'(ev_q[1]), 'h11C);
        rd(RS, 1, v); chk("mb_stat", 32'(v), 'h05);
        rd(RD, 6, v); chk("mb_data0", 32'(v), 'h1C);
        rd(RS, 1, v); chk("long_read_one_pop", 32'(v), 'h13);
        rd(RD, 1, v); chk("mb_data1", 32'(v), 'h1C);
        rd(RD, 1, v); chk("empty_data", 32'(v), 'h00);
        rd(RS, 1, v); chk("empty_stat", 32'(v), 'h00);
        ev_q.delete();

        send_frame(8'hE0, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 0);
        chk("ext_events", 32'(ev_q.size()), 1);
        chk("ext_ev", 32'(ev_q[0]), 'h375);
        rd(RS, 1, v); chk("ext_stat", 32'(v), 'h33);
        rd(RD, 1, v); chk("ext_data", 32'(v), 'h75);
        ev_q.delete();

        send_frame(8'h1C, 1'b1, 0);
        chk("perr_events", 32'(ev_q.size()), 0);
        rd(RS, 1, v); chk("perr_stat", 32'(v), 'h40);
        wr(RS, 8'h40);
        rd(RS, 1, v); chk("perr_clear", 32'(v), 'h00);

        for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b0, 0);
        chk("ovf_events", 32'(ev_q.size()), 9);
        rd(RS, 1, v); chk("ovf_stat", 32'(v), 'h8F);
        for (int i = 0; i < 8; i++) begin
            rd(RD, 1, v); chk("ovf_order", 32'(v), 32'(8'h10 + i));
        end
        rd(RS, 1, v); chk("ovf_drained", 32'(v), 'h80);
        wr(RS, 8'h80);
        rd(RS, 1, v); chk("ovf_clear", 32'(v), 'h00);

        for (int i = 0; i < 8; i++) send_frame(8'(8'h20 + i), 1'b0, 0);
        rd(RS, 1, v); chk("full_stat", 32'(v), 'h0F);
        @(negedge clk);
        zxuno_addr  = RD;
        zxuno_regrd = 1'b1;
        send_frame(8'h28, 1'b0, 1);
        rd(RS, 1, v); chk("pop_push_full_stat", 32'(v), 'h0F);
        for (int i = 0; i < 8; i++) begin
            rd(RD, 1, v); chk("pop_push_order", 32'(v), 32'(8'h21 + i));
        end
        rd(RS, 1, v); chk("pop_push_drained", 32'(v), 'h00);
        ev_q.delete();

        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        repeat (300) @(negedge clk);
        send_frame(8'h1C, 1'b0, 0);
        chk("tmo_events", 32'(ev_q.size()), 1);
        chk("tmo_ev", 32'(ev_q[0]), 'h01C);
        rd(RS, 1, v); chk("tmo_stat", 32'(v), 'h03);
        rd(RD, 1, v);
        ev_q.delete();

        send_frame(8'h33, 1'b0, 0);
        send_frame(8'h34, 1'b0, 2);
        chk("flush_events", 32'(ev_q.size()), 2);
        chk("flush_scancode", 32'(scancode), 'h34);
        rd(RS, 1, v); chk("flush_stat", 32'(v), 'h00);
        ev_q.delete();

        enable_rcv = 1'b0;
        send_frame(8'h55, 1'b0, 0);
        enable_rcv = 1'b1;
        chk("en_events", 32'(ev_q.size()), 0);
        rd(RS, 1, v); chk("en_stat", 32'(v), 'h00);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        @(negedge clk);
        enable_rcv = 1'b0;
        repeat (3) @(negedge clk);
        enable_rcv = 1'b1;
        send_frame(8'h4B, 1'b0, 0);
        chk("en_resume_events", 32'(ev_q.size()), 1);
        chk("en_resume_ev", 32'(ev_q[0]), 'h04B);
        rd(RS, 1, v); chk("en_resume_stat", 32'(v), 'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
